// File: rtl/rr_arb_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: state encoding,
// default hold limit and the rotating-priority winner search.
package rr_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam int MAX_HOLD_DEF = 8;

    // First requester found scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
    // Iterating downward lets the nearest index overwrite farther ones.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] win;
        logic [1:0] idx;
        win = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) win = idx;
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_arb4_dec.sv
// 2-to-4 one-hot decoder with enable; output is all-zero when disabled.
module dec2to4_en (
    input  logic [1:0] idx,
    input  logic       en,
    output logic [3:0] onehot
);

    always_comb begin
        onehot = en ? (4'b0001 << idx) : 4'b0000;
    end

endmodule

// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with a per-grant hold limit.
// Grant, index, busy and expired all come straight from registers.
module rr_arb4
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       En,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       expired
);

    localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    state_t          state, state_nxt;
    logic [1:0]      ptr, ptr_nxt;
    logic [1:0]      id_q, id_nxt;
    logic [HW-1:0]   hold_cnt, hold_nxt;
    logic            exp_q, exp_nxt;
    logic [1:0]      rel_ptr;
    logic [1:0]      win_cur;
    logic [1:0]      win_rel;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            ptr      <= 2'd0;
            id_q     <= 2'd0;
            hold_cnt <= '0;
            exp_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            id_q     <= id_nxt;
            hold_cnt <= hold_nxt;
            exp_q    <= exp_nxt;
        end
    end

    // On release or timeout the search restarts just past the current owner,
    // so a lone timed-out owner is found last and simply re-granted.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        id_nxt    = id_q;
        hold_nxt  = hold_cnt;
        exp_nxt   = 1'b0;
        rel_ptr   = id_q + 2'd1;
        win_cur   = rr_pick(req, ptr);
        win_rel   = rr_pick(req, rel_ptr);
        if (!En) begin
            state_nxt = ST_IDLE;
            hold_nxt  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        state_nxt = ST_GRANT;
                        id_nxt    = win_cur;
                        hold_nxt  = '0;
                    end
                end
                ST_GRANT: begin
                    if (req[id_q] && (hold_cnt != HOLD_LAST)) begin
                        hold_nxt = hold_cnt + 1'b1;
                    end else begin
                        exp_nxt  = req[id_q];
                        ptr_nxt  = rel_ptr;
                        hold_nxt = '0;
                        if (|req) begin
                            id_nxt = win_rel;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    hold_nxt  = '0;
                end
            endcase
        end
    end

    always_comb begin
        busy    = (state == ST_GRANT);
        gnt_id  = id_q;
        expired = exp_q;
    end

    dec2to4_en u_dec (
        .idx    (id_q),
        .en     (busy),
        .onehot (gnt)
    );

endmodule

// File: tb/tb_rr_arb4.sv
// Self-checking bench for rr_arb4: an independent cycle model pushes expected
// outputs into a scoreboard queue, popped and compared after each clock edge.
module tb_rr_arb4;

    localparam int MAXH = 8;

    logic       clk;
    logic       rstn;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       expired;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] gid;
        logic       busy;
        logic       exp;
    } exp_t;

    exp_t sbq[$];

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int m_own;
    int m_cnt;
    int m_ptr;
    int m_gid;
    bit m_exp;

    rr_arb4 #(.MAX_HOLD(MAXH)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .En      (en),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .expired (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int m_pick(input int p, input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_own = -1;
        m_cnt = 0;
        m_ptr = 0;
        m_gid = 0;
        m_exp = 1'b0;
    endtask

    task automatic model_step(input logic e, input logic [3:0] r);
        m_exp = 1'b0;
        if (!e) begin
            m_own = -1;
            m_cnt = 0;
        end else if (m_own < 0) begin
            if (r != 4'b0) begin
                m_own = m_pick(m_ptr, r);
                m_gid = m_own;
                m_cnt = 0;
            end
        end else if (r[m_own] && m_cnt < MAXH - 1) begin
            m_cnt++;
        end else begin
            m_exp = r[m_own];
            m_ptr = (m_own + 1) % 4;
            m_cnt = 0;
            if (r != 4'b0) begin
                m_own = m_pick(m_ptr, r);
                m_gid = m_own;
            end else begin
                m_own = -1;
            end
        end
    endtask

    // Drive one cycle of stimulus, predict, then compare after the edge.
    task automatic cyc(input logic e, input logic [3:0] r);
        exp_t x;
        exp_t got;
        en  = e;
        req = r;
        model_step(e, r);
        x.gnt  = (m_own < 0) ? 4'b0 : 4'(1 << m_own);
        x.gid  = 2'(m_gid);
        x.busy = (m_own >= 0);
        x.exp  = m_exp;
        sbq.push_back(x);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            got = sbq.pop_front();
            chk("sb_gnt", gnt, got.gnt);
            chk("sb_busy", busy, got.busy);
            chk("sb_expired", expired, got.exp);
            if (got.busy) chk("sb_gnt_id", gnt_id, got.gid);
            chk("onehot", ($countones(gnt) <= 1), 1);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        en   = 1'b0;
        req  = 4'b0;
        model_reset();
        sbq.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    int n_exp;
    int n_sw;
    logic [3:0] prev_gnt;

    initial begin
        rstn = 1'b0;
        en   = 1'b0;
        req  = 4'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_gnt_id", gnt_id, 2'd0);
        chk("rst_expired", expired, 1'b0);
        rstn = 1'b1;

        // single requester, one-cycle latency
        cyc(1'b1, 4'b0100);
        chk("r27_gnt", gnt, 4'b0100);
        chk("r27_id", gnt_id, 2'd2);
        chk("r27_busy", busy, 1'b1);

        // all requesting: rotation with a timeout at every switch
        do_reset();
        n_exp = 0;
        n_sw = 0;
        prev_gnt = 4'b0;
        cyc(1'b1, 4'b1111);
        chk("r28_first", gnt, 4'b0001);
        prev_gnt = gnt;
        for (int i = 0; i < 39; i++) begin
            cyc(1'b1, 4'b1111);
            if (expired) n_exp++;
            if (gnt != prev_gnt) n_sw++;
            prev_gnt = gnt;
        end
        chk("r28_expired_cnt", n_exp, 4);
        chk("r28_switch_cnt", n_sw, 4);
        chk("r28_last", gnt, 4'b0001);

        // release hands over at the same edge, no bubble
        do_reset();
        cyc(1'b1, 4'b0001);
        cyc(1'b1, 4'b0011);
        cyc(1'b1, 4'b0011);
        cyc(1'b1, 4'b0010);
        chk("r29_gnt", gnt, 4'b0010);
        chk("r29_busy", busy, 1'b1);
        chk("r29_expired", expired, 1'b0);

        // lone requester is re-granted after each timeout
        do_reset();
        n_exp = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 4'b1000);
            if (expired) n_exp++;
        end
        chk("r30_expired_cnt", n_exp, 2);
        chk("r30_gnt", gnt, 4'b1000);

        // enable drop keeps pointer, restart continues from it
        do_reset();
        cyc(1'b1, 4'b0010);
        cyc(1'b1, 4'b0000);
        cyc(1'b1, 4'b0010);
        chk("r31_own1", gnt, 4'b0010);
        cyc(1'b0, 4'b1111);
        chk("r31_off_gnt", gnt, 4'b0000);
        chk("r31_off_busy", busy, 1'b0);
        cyc(1'b1, 4'b1111);
        chk("r31_resume", gnt, 4'b0100);

        // asynchronous reset mid-grant
        do_reset();
        cyc(1'b1, 4'b0001);
        cyc(1'b1, 4'b0001);
        cyc(1'b1, 4'b0001);
        #2;
        rstn = 1'b0;
        #1;
        chk("r32_async_gnt", gnt, 4'b0000);
        chk("r32_async_busy", busy, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        cyc(1'b1, 4'b1010);
        chk("r32_after", gnt, 4'b0010);
        chk("r32_after_id", gnt_id, 2'd1);

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 300; i++) begin
            cyc(($urandom_range(0, 9) != 0), 4'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
